// File: rtl/spi_arb_pkg.sv
// Shared state encoding, default timing constants and sizing helper for the
// SPI requester arbiter.
package spi_arb_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE    = 3'd0,
      ARB_SETUP   = 3'd1,
      ARB_LOAD    = 3'd2,
      ARB_START   = 3'd3,
      ARB_WAIT    = 3'd4,
      ARB_NEXT    = 3'd5,
      ARB_RELEASE = 3'd6
   } arb_state_t;

   localparam int SPI_ARB_CS_SETUP = 2;
   localparam int SPI_ARB_CS_GAP   = 2;
   localparam int SPI_ARB_TIMEOUT  = 16;

   // A shared counter only ever holds 0 .. (largest count - 1).
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (c > m) ? c : m;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester fabric and spi_master handshake signals of the arbiter, with the
// arbiter as slave and the fabric/master side as master.
interface spi_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*8-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [7:0]           rsp_data;
   logic [NUM_REQ-1:0]   err_timeout;
   logic                 spi_start;
   logic [7:0]           spi_tx_data;
   logic [7:0]           spi_rx_data;
   logic                 spi_done;

   modport slave (
      input  req_valid, req_data, req_last, spi_rx_data, spi_done,
      output req_ready, rsp_valid, rsp_data, err_timeout, spi_start, spi_tx_data
   );

   modport master (
      output req_valid, req_data, req_last, spi_rx_data, spi_done,
      input  req_ready, rsp_valid, rsp_data, err_timeout, spi_start, spi_tx_data
   );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping modulo N.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic [IW-1:0] pos_s;
   logic          hit_s;

   // Walk the requests starting at ptr_i; the first hit wins.
   always_comb begin
      gnt_o = {N{1'b0}};
      idx_o = {IW{1'b0}};
      any_o = 1'b0;
      pos_s = {IW{1'b0}};
      hit_s = 1'b0;
      for (int k = 0; k < N; k++) begin
         pos_s        = ((int'(ptr_i) + k) >= N) ? IW'(int'(ptr_i) + k - N)
                                                 : IW'(int'(ptr_i) + k);
         hit_s        = req_i[pos_s] & ~any_o;
         gnt_o[pos_s] = gnt_o[pos_s] | hit_s;
         idx_o        = hit_s ? pos_s : idx_o;
         any_o        = any_o | req_i[pos_s];
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spi_master between NUM_REQ requesters: round-robin grant held for
// a whole burst, per-device chip-select with setup/gap timing, byte timeout.
module spi_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int CS_SETUP = SPI_ARB_CS_SETUP,
   parameter int CS_GAP   = SPI_ARB_CS_GAP,
   parameter int TIMEOUT  = SPI_ARB_TIMEOUT
) (
   input  logic               clk,
   input  logic               rst_n,
   spi_arbiter_if.slave       bus,
   output logic [NUM_REQ-1:0] dev_cs_n_o,
   output logic               busy_o
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int CW = cnt_width(CS_SETUP, CS_GAP, TIMEOUT);

   localparam logic [2:0] S_IDLE    = 3'(ARB_IDLE);
   localparam logic [2:0] S_SETUP   = 3'(ARB_SETUP);
   localparam logic [2:0] S_LOAD    = 3'(ARB_LOAD);
   localparam logic [2:0] S_START   = 3'(ARB_START);
   localparam logic [2:0] S_WAIT    = 3'(ARB_WAIT);
   localparam logic [2:0] S_NEXT    = 3'(ARB_NEXT);
   localparam logic [2:0] S_RELEASE = 3'(ARB_RELEASE);

   logic [2:0]         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [IW-1:0]      gnt_q, gnt_d;
   logic [NUM_REQ-1:0] gnt_oh_q, gnt_oh_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic               last_q, last_d;
   logic [7:0]         tx_q, tx_d;
   logic [7:0]         rsp_data_q, rsp_data_d;
   logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [NUM_REQ-1:0] err_q, err_d;
   logic [NUM_REQ-1:0] cs_n_q, cs_n_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;

   logic               rsp_fire_s;
   logic               err_fire_s;
   logic               rsp_pend_s;
   logic [7:0]         req_byte_s;
   logic [NUM_REQ-1:0] arb_gnt_s;
   logic [IW-1:0]      arb_idx_s;
   logic               arb_any_s;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .req_i (bus.req_valid),
      .ptr_i (ptr_q),
      .gnt_o (arb_gnt_s),
      .idx_o (arb_idx_s),
      .any_o (arb_any_s)
   );

   assign req_byte_s = bus.req_data[{gnt_q, 3'b000} +: 8];
   // The WAIT exit waits one cycle behind spi_done so rsp_valid leads the state change.
   assign rsp_pend_s = |rsp_valid_q;

   // Next-state, counters and datapath capture.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      gnt_d      = gnt_q;
      gnt_oh_d   = gnt_oh_q;
      ptr_d      = ptr_q;
      last_d     = last_q;
      tx_d       = tx_q;
      rsp_data_d = rsp_data_q;
      rsp_fire_s = 1'b0;
      err_fire_s = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (arb_any_s) begin
               gnt_d    = arb_idx_s;
               gnt_oh_d = arb_gnt_s;
               cnt_d    = CW'(0);
               state_d  = S_SETUP;
            end else begin
               state_d  = S_IDLE;
            end
         end
         S_SETUP: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               cnt_d   = CW'(0);
               state_d = S_LOAD;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         S_LOAD: begin
            tx_d    = req_byte_s;
            last_d  = bus.req_last[gnt_q];
            state_d = S_START;
         end
         S_START: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (rsp_pend_s) begin
               cnt_d   = CW'(0);
               state_d = last_q ? S_RELEASE : S_NEXT;
            end else if (bus.spi_done) begin
               rsp_fire_s = 1'b1;
               rsp_data_d = bus.spi_rx_data;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_NEXT: begin
            if (bus.req_valid[gnt_q]) begin
               state_d = S_LOAD;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_fire_s = 1'b1;
               cnt_d      = CW'(0);
               state_d    = S_RELEASE;
            end else begin
               cnt_d      = cnt_q + CW'(1);
            end
         end
         S_RELEASE: begin
            if (cnt_q == CW'(CS_GAP - 1)) begin
               cnt_d   = CW'(0);
               ptr_d   = (gnt_q == IW'(NUM_REQ - 1)) ? IW'(0) : gnt_q + IW'(1);
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + CW'(1);
            end
         end
         default: begin
            cnt_d   = CW'(0);
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so every port comes from a flop.
   always_comb begin
      req_ready_d = (state_d == S_LOAD) ? gnt_oh_d : {NUM_REQ{1'b0}};
      cs_n_d      = (state_d inside {S_SETUP, S_LOAD, S_START, S_WAIT, S_NEXT})
                    ? ~gnt_oh_d : {NUM_REQ{1'b1}};
      start_d     = (state_d == S_START);
      busy_d      = (state_d != S_IDLE);
      rsp_valid_d = rsp_fire_s ? gnt_oh_q : {NUM_REQ{1'b0}};
      err_d       = err_fire_s ? gnt_oh_q : {NUM_REQ{1'b0}};
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= CW'(0);
         gnt_q       <= IW'(0);
         gnt_oh_q    <= {NUM_REQ{1'b0}};
         ptr_q       <= IW'(0);
         last_q      <= 1'b0;
         tx_q        <= 8'h00;
         rsp_data_q  <= 8'h00;
         req_ready_q <= {NUM_REQ{1'b0}};
         rsp_valid_q <= {NUM_REQ{1'b0}};
         err_q       <= {NUM_REQ{1'b0}};
         cs_n_q      <= {NUM_REQ{1'b1}};
         start_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         gnt_oh_q    <= gnt_oh_d;
         ptr_q       <= ptr_d;
         last_q      <= last_d;
         tx_q        <= tx_d;
         rsp_data_q  <= rsp_data_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         err_q       <= err_d;
         cs_n_q      <= cs_n_d;
         start_q     <= start_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_data    = rsp_data_q;
   assign bus.err_timeout = err_q;
   assign bus.spi_start   = start_q;
   assign bus.spi_tx_data = tx_q;
   assign dev_cs_n_o      = cs_n_q;
   assign busy_o          = busy_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: table of single-byte bursts plus hand-written
// multi-byte, timeout and mid-burst reset sequences, all cycle-exact.
module tb_spi_arbiter;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] dev_cs_n;
   logic       busy;

   int n_checks = 0;
   int n_pass   = 0;

   spi_arbiter_if #(.NUM_REQ(4)) bus ();

   spi_arbiter #(
      .NUM_REQ  (4),
      .CS_SETUP (2),
      .CS_GAP   (2),
      .TIMEOUT  (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .dev_cs_n_o (dev_cs_n),
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [3:0] valid;
      int         gnt;
      logic [7:0] tx;
      logic [7:0] rx;
   } vec_t;

   vec_t vecs [11];

   function automatic logic [3:0] oh(input int g);
      logic [3:0] r;
      r    = 4'b0000;
      r[g] = 1'b1;
      return r;
   endfunction

   function automatic logic [3:0] csn(input int g);
      logic [3:0] r;
      r    = 4'b1111;
      r[g] = 1'b0;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      bus.req_valid   = 4'b0000;
      bus.req_last    = 4'b0000;
      bus.req_data    = 32'h0;
      bus.spi_done    = 1'b0;
      bus.spi_rx_data = 8'h00;
      #1;
      check("rst_cs", dev_cs_n, 4'b1111);
      check("rst_busy", busy, 1'b0);
      check("rst_start", bus.spi_start, 1'b0);
      check("rst_ready", bus.req_ready, 4'b0000);
      check("rst_rsp_valid", bus.rsp_valid, 4'b0000);
      check("rst_err", bus.err_timeout, 4'b0000);
      check("rst_tx", bus.spi_tx_data, 8'h00);
      check("rst_rsp_data", bus.rsp_data, 8'h00);
      step();
      step();
      rst_n = 1'b1;
   endtask

   // Called at the IDLE cycle where the request is presented; returns in LOAD.
   task automatic begin_burst(input int g);
      step();
      check("setup1_cs", dev_cs_n, csn(g));
      check("setup1_busy", busy, 1'b1);
      check("setup1_ready", bus.req_ready, 4'b0000);
      step();
      check("setup2_cs", dev_cs_n, csn(g));
      check("setup2_start", bus.spi_start, 1'b0);
      step();
   endtask

   // Called in LOAD; returns in the rsp_valid cycle.
   task automatic byte_xfer(input int g, input logic [7:0] tx, input logic [7:0] rx, input int lat);
      check("load_ready", bus.req_ready, oh(g));
      check("load_cs", dev_cs_n, csn(g));
      check("load_start", bus.spi_start, 1'b0);
      step();
      check("start_pulse", bus.spi_start, 1'b1);
      check("start_tx", bus.spi_tx_data, tx);
      check("start_ready", bus.req_ready, 4'b0000);
      step();
      check("wait_start", bus.spi_start, 1'b0);
      for (int k = 0; k < lat; k++) begin
         step();
         check("wait_rsp", bus.rsp_valid, 4'b0000);
         check("wait_tx_hold", bus.spi_tx_data, tx);
      end
      bus.spi_done    = 1'b1;
      bus.spi_rx_data = rx;
      step();
      bus.spi_done    = 1'b0;
      check("rsp_valid", bus.rsp_valid, oh(g));
      check("rsp_data", bus.rsp_data, rx);
      check("rsp_cs", dev_cs_n, csn(g));
   endtask

   // Called in the final rsp_valid cycle; returns in IDLE.
   task automatic end_burst();
      step();
      check("rel1_cs", dev_cs_n, 4'b1111);
      check("rel1_rsp", bus.rsp_valid, 4'b0000);
      step();
      check("rel2_cs", dev_cs_n, 4'b1111);
      check("rel2_busy", busy, 1'b1);
      step();
      check("idle_busy", busy, 1'b0);
      check("idle_cs", dev_cs_n, 4'b1111);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid   = 4'b0000;
      bus.req_last    = 4'b0000;
      bus.req_data    = 32'h0;
      bus.spi_done    = 1'b0;
      bus.spi_rx_data = 8'h00;

      vecs[0]  = '{1'b1, 4'b0010, 1, 8'hCA, 8'h35};
      vecs[1]  = '{1'b1, 4'b1011, 0, 8'h10, 8'h90};
      vecs[2]  = '{1'b0, 4'b1011, 1, 8'h21, 8'h91};
      vecs[3]  = '{1'b0, 4'b1011, 3, 8'h33, 8'h93};
      vecs[4]  = '{1'b0, 4'b1011, 0, 8'h40, 8'h94};
      vecs[5]  = '{1'b0, 4'b1000, 3, 8'h5F, 8'hA5};
      vecs[6]  = '{1'b0, 4'b1001, 0, 8'h66, 8'hB6};
      vecs[7]  = '{1'b0, 4'b0100, 2, 8'h7E, 8'hC7};
      vecs[8]  = '{1'b0, 4'b0110, 1, 8'h81, 8'h18};
      vecs[9]  = '{1'b0, 4'b1111, 2, 8'h9C, 8'h29};
      vecs[10] = '{1'b0, 4'b0011, 0, 8'hA0, 8'h3A};

      #2;
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].rst) do_reset();
         for (int b = 0; b < 4; b++)
            bus.req_data[b*8 +: 8] = (b == vecs[i].gnt) ? vecs[i].tx : (8'hE0 | 8'(b));
         bus.req_last  = 4'b1111;
         bus.req_valid = vecs[i].valid;
         begin_burst(vecs[i].gnt);
         byte_xfer(vecs[i].gnt, vecs[i].tx, vecs[i].rx, 0);
         bus.req_valid = 4'b0000;
         end_burst();
      end

      // Three-byte burst from requester 2 while requester 0 waits (ptr is 1).
      bus.req_data  = {8'h00, 8'h01, 8'h00, 8'hF0};
      bus.req_last  = 4'b0001;
      bus.req_valid = 4'b0101;
      begin_burst(2);
      byte_xfer(2, 8'h01, 8'hA1, 2);
      bus.req_data[23:16] = 8'h02;
      step();
      check("next1_cs", dev_cs_n, 4'b1011);
      check("next1_start", bus.spi_start, 1'b0);
      step();
      byte_xfer(2, 8'h02, 8'hA2, 0);
      bus.req_data[23:16] = 8'h03;
      bus.req_last[2]     = 1'b1;
      step();
      check("next2_cs", dev_cs_n, 4'b1011);
      step();
      byte_xfer(2, 8'h03, 8'hA3, 1);
      bus.req_valid[2] = 1'b0;
      end_burst();
      begin_burst(0);
      byte_xfer(0, 8'hF0, 8'hB0, 0);
      bus.req_valid = 4'b0000;
      end_burst();

      // Timeout: one byte without last, then valid drops.
      bus.req_data  = {24'h0, 8'hAA};
      bus.req_last  = 4'b0000;
      bus.req_valid = 4'b0001;
      begin_burst(0);
      byte_xfer(0, 8'hAA, 8'h55, 0);
      bus.req_valid = 4'b0000;
      for (int k = 0; k < 16; k++) begin
         step();
         check("to_wait_cs", dev_cs_n, 4'b1110);
         check("to_wait_err", bus.err_timeout, 4'b0000);
         check("to_wait_start", bus.spi_start, 1'b0);
      end
      step();
      check("to_err", bus.err_timeout, 4'b0001);
      check("to_cs", dev_cs_n, 4'b1111);
      step();
      check("to_err_pulse", bus.err_timeout, 4'b0000);
      check("to_no_start", bus.spi_start, 1'b0);
      step();
      check("to_idle_busy", busy, 1'b0);

      // A valid on the last counted NEXT cycle beats the timeout.
      bus.req_data  = {24'h0, 8'hAB};
      bus.req_valid = 4'b0001;
      begin_burst(0);
      byte_xfer(0, 8'hAB, 8'h5B, 0);
      bus.req_valid = 4'b0000;
      for (int k = 0; k < 16; k++) begin
         step();
         check("late_err", bus.err_timeout, 4'b0000);
      end
      bus.req_data  = {24'h0, 8'hAC};
      bus.req_last  = 4'b0001;
      bus.req_valid = 4'b0001;
      step();
      check("late_no_err", bus.err_timeout, 4'b0000);
      byte_xfer(0, 8'hAC, 8'h5C, 0);
      bus.req_valid = 4'b0000;
      end_burst();

      // Reset while WAITing for requester 2 (ptr is 1 beforehand).
      bus.req_data  = {8'h00, 8'h5A, 16'h0};
      bus.req_last  = 4'b0100;
      bus.req_valid = 4'b0100;
      begin_burst(2);
      check("rw_ready", bus.req_ready, 4'b0100);
      step();
      check("rw_start", bus.spi_start, 1'b1);
      step();
      check("rw_cs_before", dev_cs_n, 4'b1011);
      do_reset();
      bus.spi_done    = 1'b1;
      bus.spi_rx_data = 8'h77;
      step();
      bus.spi_done = 1'b0;
      check("rw_no_rsp", bus.rsp_valid, 4'b0000);
      check("rw_idle", busy, 1'b0);
      step();
      check("rw_no_rsp2", bus.rsp_valid, 4'b0000);
      bus.req_data  = {8'h00, 8'h22, 8'h00, 8'h11};
      bus.req_last  = 4'b0101;
      bus.req_valid = 4'b0101;
      begin_burst(0);
      byte_xfer(0, 8'h11, 8'h61, 0);
      bus.req_valid = 4'b0100;
      end_burst();
      begin_burst(2);
      byte_xfer(2, 8'h22, 8'h62, 0);
      bus.req_valid = 4'b0000;
      end_burst();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spi_arbiter.md
# spi_arbiter

Shares one `spi_master` instance between `NUM_REQ` requesters, each owning one SPI slave device. It arbitrates round-robin between requesters and holds the grant for a whole multi-byte burst. It drives the master's `start_transaction`/`tx_data` handshake and sequences a per-device chip-select with setup and inter-burst gap timing. Each received byte is returned to the owning requester. The block sits between the requester fabric and `spi_master`.

## Interface
- `NUM_REQ`, 4: number of requesters/devices (2..8)
- `CS_SETUP`, 2: cycles `dev_cs_n` is low before the first `spi_start` of a burst (≥1)
- `CS_GAP`, 2: cycles `dev_cs_n` stays high after a burst before the next grant (≥1)
- `TIMEOUT`, 16: maximum wait in cycles for the next byte of an open burst
- `clk  in  1`: clock
- `rst_n  in  1`: reset; asynchronous, active-low
- `req_valid  in  NUM_REQ`: requester i has a byte on `req_data[i]`
- `req_data  in  NUM_REQ*8`: flattened; byte i is `[8i+7:8i]`
- `req_last  in  NUM_REQ`: the byte is the last one of its burst
- `req_ready  out  NUM_REQ`: one-hot, one-cycle accept; a byte transfers when `valid & ready`
- `rsp_valid  out  NUM_REQ`: one-hot, one-cycle pulse; `rsp_data` is valid for that requester
- `rsp_data  out  8`: received byte
- `err_timeout  out  NUM_REQ`: one-cycle pulse on a burst abort
- `spi_start  out  1`: to master `start_transaction`
- `spi_tx_data  out  8`: to master `tx_data`
- `spi_rx_data  in  8`: from master `rx_data`
- `spi_done  in  1`: from master `transaction_done`
- `dev_cs_n  out  NUM_REQ`: per-device chip select, active-low
- `busy  out  1`: high in every state except IDLE

## Operation
- States: IDLE, SETUP, LOAD, START, WAIT, NEXT, RELEASE.
- **IDLE**
  - If any `req_valid` is set, the arbiter picks the first set bit searching upward from `ptr` (wrapping).
  - The winner is registered as `gnt`, and the state moves to SETUP.
- **SETUP**: `dev_cs_n[gnt]`=0; count `CS_SETUP` cycles, then go to LOAD.
- **LOAD**: `req_ready[gnt]`=1 for one cycle. Capture `req_data[gnt]` into `spi_tx_data` and `req_last[gnt]` into `last_q`. Go to START.
- **START**: `spi_start`=1 for exactly one cycle. Go to WAIT.
- **WAIT**: hold `spi_tx_data`. On `spi_done`:
  - pulse `rsp_valid[gnt]`, with `rsp_data`=`spi_rx_data` captured that cycle;
  - go to RELEASE if `last_q`, else go to NEXT.
- **NEXT**: `dev_cs_n[gnt]` stays low.
  - `req_valid[gnt]` → LOAD.
  - `TIMEOUT` cycles with no valid → pulse `err_timeout[gnt]`, then RELEASE.
- **RELEASE**: all `dev_cs_n` high. Count `CS_GAP` cycles, set `ptr` = (`gnt`+1) mod `NUM_REQ`, go to IDLE.
- Only `gnt` ever sees `req_ready`, `rsp_valid` or a low `dev_cs_n`. At most one `dev_cs_n` bit is low at any time.
- Requests from other requesters during a burst are ignored; they are arbitrated in the next IDLE.
- `spi_done` outside WAIT is ignored.
- `rsp_valid` has no backpressure; requesters must sink it.

## Timing
- Reset values:
  - `dev_cs_n` all 1; `ptr`=0; state IDLE.
  - `spi_start`, `req_ready`, `rsp_valid`, `err_timeout`, `busy` = 0.
  - `spi_tx_data`, `rsp_data` = 0.
- Reset asserted mid-burst: all outputs return to reset values asynchronously. No `rsp_valid` or `err_timeout` is emitted for the aborted byte.
- First byte, from `req_valid` seen in IDLE at cycle t:
  - SETUP occupies t+1 .. t+`CS_SETUP`;
  - `req_ready` at t+`CS_SETUP`+1;
  - `spi_start` at t+`CS_SETUP`+2.
- `rsp_valid` is asserted the cycle after `spi_done`.
- Subsequent bytes of a burst, with `req_valid` already high: `spi_start` comes 3 cycles after `rsp_valid`. CS is not toggled between bytes.
- After the final `rsp_valid`: `dev_cs_n` goes high 1 cycle later and stays high for `CS_GAP` cycles. The earliest next SETUP is 1 cycle after that.
- `TIMEOUT` counting starts on the first NEXT cycle. A valid arriving on the last counted cycle wins over the timeout.

## Structure
- Package `spi_arb_pkg` holds:
  - the `arb_state_t` enum;
  - default constants `SPI_ARB_CS_SETUP`, `SPI_ARB_CS_GAP`, `SPI_ARB_TIMEOUT`.
- Sub-module `rr_arbiter`:
  - combinational round-robin pick;
  - inputs: request vector and `ptr`;
  - outputs: one-hot grant plus index.
- The top level owns the FSM, counters and datapath registers.

## Test plan
- Single request: requester 1 sends 0xCA with `last` and a master model returns 0x35.
  - `dev_cs_n`=4'b1101 for `CS_SETUP` cycles, then `spi_tx_data`=0xCA with a one-cycle `spi_start`.
  - `rsp_valid`=4'b0010 with `rsp_data`=0x35.
  - `dev_cs_n` returns high for 2 cycles.
- Simultaneous `req_valid`=4'b1011 after reset: grants in order 0, 1, 3, then 0 again. The `CS_GAP` separation is checked between each grant.
- Three-byte burst from requester 2 (0x01, 0x02, 0x03+`last`), with requester 0 also requesting:
  - `dev_cs_n[2]` stays low across all three `spi_start`s;
  - requester 0 is granted only after RELEASE.
- Timeout: requester 0 sends 0xAA without `last` and then drops valid.
  - `err_timeout`=4'b0001 fires 16 cycles into NEXT;
  - `dev_cs_n` goes high, and no further `spi_start` is issued.
- Reset pulse during WAIT:
  - all `dev_cs_n` high and `spi_start` 0 immediately;
  - a later `spi_done` produces no `rsp_valid`;
  - after release, requester 0 is granted first (`ptr`=0).
- Wrap: requester 3 completes a burst, then requesters 0 and 3 request → requester 0 is granted.
